// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-id and ALU-op widths, ALU opcodes,
// the control bundle that every inter-stage register carries, and the BUBBLE
// value those registers load when a slot is squashed or stalled.
package pipe_pkg;

  localparam int REG_ID_W = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  // Control fields that travel with an instruction between stages.
  typedef struct packed {
    logic                valid;
    logic                we_regfile;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
  } pipe_ctrl_t;

  // A bubble: nothing valid, no side effects, ALU op 0.
  localparam pipe_ctrl_t BUBBLE = '0;

  // True when an instruction actually reads 'src' and it names register 'rd'.
  function automatic logic src_match(input logic                uses,
                                     input logic [REG_ID_W-1:0] src,
                                     input logic [REG_ID_W-1:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on 'inc' and sticks at all-ones instead of
// wrapping, so a long run never reports a misleadingly small count.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Next value for one increment, held at the ceiling once reached.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Count events; cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use detection. A load in EX whose
// destination is read by the instruction in ID stalls the front end for one
// cycle while a bubble goes into EX; a flush squashes the decode slot, and a
// flush seen during a hold is remembered until the hold releases.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 id_valid,
  input  logic [REG_ID_W-1:0]  id_rs1_id,
  input  logic [REG_ID_W-1:0]  id_rs2_id,
  input  logic [REG_ID_W-1:0]  id_rd_id,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [DWIDTH-1:0]    id_rs1_data,
  input  logic [DWIDTH-1:0]    id_rs2_data,
  input  logic [DWIDTH-1:0]    id_imm,
  input  logic [DWIDTH-1:0]    id_pc,
  input  logic                 id_we_regfile,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 stall_id,
  output logic                 ex_valid,
  output logic [REG_ID_W-1:0]  ex_rs1_id,
  output logic [REG_ID_W-1:0]  ex_rs2_id,
  output logic [REG_ID_W-1:0]  ex_rd_id,
  output logic [DWIDTH-1:0]    ex_rs1_data,
  output logic [DWIDTH-1:0]    ex_rs2_data,
  output logic [DWIDTH-1:0]    ex_imm,
  output logic [DWIDTH-1:0]    ex_pc,
  output logic                 ex_we_regfile,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  logic flush_pending;
  logic load_use;
  logic flush_eff;
  logic insert_bubble;
  logic stall_evt;

  // A load to x0 never produces a value, so it cannot create a hazard.
  assign load_use = ex_valid && ex_mem_read && (ex_rd_id != '0) && id_valid &&
                    (src_match(id_uses_rs1, id_rs1_id, ex_rd_id) ||
                     src_match(id_uses_rs2, id_rs2_id, ex_rd_id));

  // A flush parked during a hold takes effect on the first free edge.
  assign flush_eff = (flush || flush_pending) && !hold;

  // The squashed slot no longer needs its operand, so a flush cancels the stall.
  assign stall_id = hold || (load_use && !flush_eff);

  assign insert_bubble = flush_eff || load_use;
  assign stall_evt     = !hold && !flush_eff && load_use;

  // ---- ID -> EX boundary: hold, then flush, then load-use bubble, then capture ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_pending <= 1'b0;
      ex_valid      <= BUBBLE.valid;
      ex_we_regfile <= BUBBLE.we_regfile;
      ex_mem_read   <= BUBBLE.mem_read;
      ex_mem_write  <= BUBBLE.mem_write;
      ex_alu_op     <= BUBBLE.alu_op;
      ex_rs1_id     <= '0;
      ex_rs2_id     <= '0;
      ex_rd_id      <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
    end else if (hold) begin
      flush_pending <= flush_pending || flush;
    end else if (insert_bubble) begin
      flush_pending <= 1'b0;
      ex_valid      <= BUBBLE.valid;
      ex_we_regfile <= BUBBLE.we_regfile;
      ex_mem_read   <= BUBBLE.mem_read;
      ex_mem_write  <= BUBBLE.mem_write;
      ex_alu_op     <= BUBBLE.alu_op;
      ex_rs1_id     <= '0;
      ex_rs2_id     <= '0;
      ex_rd_id      <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
    end else begin
      flush_pending <= 1'b0;
      ex_valid      <= id_valid;
      ex_we_regfile <= id_we_regfile;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_alu_op     <= id_alu_op;
      ex_rs1_id     <= id_rs1_id;
      ex_rs2_id     <= id_rs2_id;
      ex_rd_id      <= id_rd_id;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_pc         <= id_pc;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (stall_evt),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (flush_eff),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboarded bench for the ID/EX hazard register. Each directed vector is
// driven on the falling edge and carries the hand-computed view expected
// during that cycle: stall_id for the applied inputs and the EX state left by
// the previous rising edge. A monitor pops and compares mid-cycle.
module tb_id_ex_hazard_stage;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic          id_valid;
  logic [4:0]    id_rs1_id, id_rs2_id, id_rd_id;
  logic          id_uses_rs1, id_uses_rs2;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic          id_we_regfile, id_mem_read, id_mem_write;
  logic [3:0]    id_alu_op;
  logic          flush, hold;
  logic          stall_id;
  logic          ex_valid;
  logic [4:0]    ex_rs1_id, ex_rs2_id, ex_rd_id;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic          ex_we_regfile, ex_mem_read, ex_mem_write;
  logic [3:0]    ex_alu_op;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_hazard_stage #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id), .id_rd_id(id_rd_id),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_we_regfile(id_we_regfile), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .flush(flush), .hold(hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id), .ex_rd_id(ex_rd_id),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_we_regfile(ex_we_regfile), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_op(ex_alu_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr;
    logic [31:0] pc;
    logic        fl, hd;
  } in_t;

  typedef struct {
    string       tag;
    logic        stall;
    logic        valid;
    logic [4:0]  rd, rs1, rs2;
    logic        mr;
    logic [31:0] pc;
    logic [1:0]  scnt, fcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic in_t mk_in(input logic v, input logic [4:0] rs1, rs2, rd,
                                input logic u1, u2, mr, input logic [31:0] pc,
                                input logic fl, hd);
    in_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2;
    r.mr = mr; r.pc = pc; r.fl = fl; r.hd = hd;
    return r;
  endfunction

  function automatic exp_t mk_ex(input logic stall, valid, input logic [4:0] rd, rs1, rs2,
                                 input logic mr, input logic [31:0] pc,
                                 input logic [1:0] scnt, fcnt);
    exp_t r;
    r.tag = ""; r.stall = stall; r.valid = valid; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.mr = mr; r.pc = pc; r.scnt = scnt; r.fcnt = fcnt;
    return r;
  endfunction

  // Payload fields are tied to pc so every captured slot is recognisable.
  task automatic drive(input in_t i);
    id_valid      = i.v;
    id_rs1_id     = i.rs1;
    id_rs2_id     = i.rs2;
    id_rd_id      = i.rd;
    id_uses_rs1   = i.u1;
    id_uses_rs2   = i.u2;
    id_mem_read   = i.mr;
    id_pc         = i.pc;
    id_rs1_data   = i.pc * 3;
    id_rs2_data   = i.pc << 8;
    id_imm        = i.pc << 4;
    id_alu_op     = i.pc[5:2];
    id_we_regfile = i.v;
    id_mem_write  = i.pc[2];
    flush         = i.fl;
    hold          = i.hd;
  endtask

  task automatic vec(input string tag, input in_t i, input exp_t e);
    @(negedge clk);
    rstn = 1'b1;
    drive(i);
    e.tag = tag;
    q.push_back(e);
  endtask

  // Drops reset mid-cycle; the monitor samples before the next rising edge.
  task automatic reset_vec(input string tag);
    exp_t e;
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    #1 rstn = 1'b0;
    e = mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 2'd0);
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "stall_id",    {31'b0, stall_id},      {31'b0, e.stall});
        chk(e.tag, "ex_valid",    {31'b0, ex_valid},      {31'b0, e.valid});
        chk(e.tag, "ex_rd_id",    {27'b0, ex_rd_id},      {27'b0, e.rd});
        chk(e.tag, "ex_rs1_id",   {27'b0, ex_rs1_id},     {27'b0, e.rs1});
        chk(e.tag, "ex_rs2_id",   {27'b0, ex_rs2_id},     {27'b0, e.rs2});
        chk(e.tag, "ex_mem_read", {31'b0, ex_mem_read},   {31'b0, e.mr});
        chk(e.tag, "ex_pc",       ex_pc,                  e.pc);
        chk(e.tag, "ex_rs1_data", ex_rs1_data,            e.pc * 3);
        chk(e.tag, "ex_rs2_data", ex_rs2_data,            e.pc << 8);
        chk(e.tag, "ex_imm",      ex_imm,                 e.pc << 4);
        chk(e.tag, "ex_alu_op",   {28'b0, ex_alu_op},     {28'b0, e.pc[5:2]});
        chk(e.tag, "ex_we",       {31'b0, ex_we_regfile}, {31'b0, e.valid});
        chk(e.tag, "ex_mem_wr",   {31'b0, ex_mem_write},  {31'b0, e.pc[2]});
        chk(e.tag, "stall_cnt",   {30'b0, stall_cnt},     {30'b0, e.scnt});
        chk(e.tag, "flush_cnt",   {30'b0, flush_cnt},     {30'b0, e.fcnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t         idle, lw5, add, pc124;
    logic [1:0]  sat_exp [5];
    logic [31:0] pl, prev_pc;

    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rstn = 1'b0;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    drive(idle);

    reset_vec("reset");

    // Load-use: lw x5 then add x6,x5,x1
    lw5 = mk_in(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 32'h100, 0, 0);
    add = mk_in(1, 5'd5, 5'd1, 5'd6, 1, 1, 0, 32'h104, 0, 0);
    vec("lu_lw",   lw5,  mk_ex(0, 0, 0, 0, 0, 0, 32'h0,   2'd0, 2'd0));
    vec("lu_stall", add, mk_ex(1, 1, 5'd5, 5'd2, 5'd0, 1, 32'h100, 2'd0, 2'd0));
    vec("lu_bubble", add, mk_ex(0, 0, 0, 0, 0, 0, 32'h0,   2'd1, 2'd0));
    vec("lu_add",  idle, mk_ex(0, 1, 5'd6, 5'd5, 5'd1, 0, 32'h104, 2'd1, 2'd0));

    // No false stall: lw x0, and rs2 match without uses_rs2
    vec("nf_lwx0", mk_in(1, 5'd3, 5'd0, 5'd0, 1, 0, 1, 32'h108, 0, 0),
        mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd1, 2'd0));
    vec("nf_usex0", mk_in(1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 32'h10C, 0, 0),
        mk_ex(0, 1, 5'd0, 5'd3, 5'd0, 1, 32'h108, 2'd1, 2'd0));
    vec("nf_lw5", mk_in(1, 5'd4, 5'd0, 5'd5, 1, 0, 1, 32'h110, 0, 0),
        mk_ex(0, 1, 5'd7, 5'd0, 5'd0, 0, 32'h10C, 2'd1, 2'd0));
    vec("nf_nors2", mk_in(1, 5'd9, 5'd5, 5'd8, 1, 0, 0, 32'h114, 0, 0),
        mk_ex(0, 1, 5'd5, 5'd4, 5'd0, 1, 32'h110, 2'd1, 2'd0));

    // Flush beats load-use
    vec("fl_lw", mk_in(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 32'h118, 0, 0),
        mk_ex(0, 1, 5'd8, 5'd9, 5'd5, 0, 32'h114, 2'd1, 2'd0));
    vec("fl_both", mk_in(1, 5'd0, 5'd5, 5'd10, 0, 1, 0, 32'h11C, 1, 0),
        mk_ex(0, 1, 5'd5, 5'd1, 5'd0, 1, 32'h118, 2'd1, 2'd0));
    vec("fl_bubble", idle, mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd1, 2'd1));

    // Flush pulsed during a 3-cycle hold
    pc124 = mk_in(1, 5'd1, 5'd2, 5'd14, 1, 1, 0, 32'h124, 0, 0);
    vec("hd_load", mk_in(1, 5'd11, 5'd12, 5'd13, 1, 1, 0, 32'h120, 0, 0),
        mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd1, 2'd1));
    vec("hd_c1", mk_in(1, 5'd1, 5'd2, 5'd14, 1, 1, 0, 32'h124, 1, 1),
        mk_ex(1, 1, 5'd13, 5'd11, 5'd12, 0, 32'h120, 2'd1, 2'd1));
    vec("hd_c2", mk_in(1, 5'd1, 5'd2, 5'd14, 1, 1, 0, 32'h124, 0, 1),
        mk_ex(1, 1, 5'd13, 5'd11, 5'd12, 0, 32'h120, 2'd1, 2'd1));
    vec("hd_c3", mk_in(1, 5'd1, 5'd2, 5'd14, 1, 1, 0, 32'h124, 0, 1),
        mk_ex(1, 1, 5'd13, 5'd11, 5'd12, 0, 32'h120, 2'd1, 2'd1));
    vec("hd_frozen", pc124, mk_ex(0, 1, 5'd13, 5'd11, 5'd12, 0, 32'h120, 2'd1, 2'd1));
    vec("hd_bubble", pc124, mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd1, 2'd2));
    vec("hd_resume", mk_in(1, 5'd3, 5'd4, 5'd15, 1, 1, 0, 32'h128, 0, 0),
        mk_ex(0, 1, 5'd14, 5'd1, 5'd2, 0, 32'h124, 2'd1, 2'd2));

    // Asynchronous reset while ex_valid=1
    reset_vec("rst_mid");

    // Saturation: five load-use events on a 2-bit counter
    prev_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      pl = 32'h200 + 32'(i) * 32'h10;
      if (i == 0)
        vec("sat_lw", mk_in(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, pl, 0, 0),
            mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 2'd0));
      else
        vec("sat_lw", mk_in(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, pl, 0, 0),
            mk_ex(0, 1, 5'd6, 5'd5, 5'd1, 0, prev_pc, sat_exp[i-1], 2'd0));
      vec("sat_stall", mk_in(1, 5'd5, 5'd1, 5'd6, 1, 1, 0, pl + 4, 0, 0),
          mk_ex(1, 1, 5'd5, 5'd1, 5'd0, 1, pl, (i == 0) ? 2'd0 : sat_exp[i-1], 2'd0));
      vec("sat_bubble", mk_in(1, 5'd5, 5'd1, 5'd6, 1, 1, 0, pl + 4, 0, 0),
          mk_ex(0, 0, 0, 0, 0, 0, 32'h0, sat_exp[i], 2'd0));
      prev_pc = pl + 4;
    end
    vec("sat_last", idle, mk_ex(0, 1, 5'd6, 5'd5, 5'd1, 0, prev_pc, 2'd3, 2'd0));
    vec("sat_stay", idle, mk_ex(0, 0, 0, 0, 0, 0, 32'h0, 2'd3, 2'd0));

    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
